// File: rtl/pipe_pkg.sv
// Shared decode-stage definitions: default widths, immediate select codes
// and the ID/EX register bundle.
package pipe_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_INSTR_W  = 16;
    localparam int DEF_NUM_REGS = 8;
    localparam int DEF_SEL_W    = 3;
    localparam int DEF_PEND_W   = 2;

    typedef enum logic [2:0] {
        IMM_S5  = 3'd0,
        IMM_Z5  = 3'd1,
        IMM_S8  = 3'd2,
        IMM_Z8  = 3'd3,
        IMM_S11 = 3'd4
    } imm_sel_e;

    typedef struct packed {
        logic                  valid;
        logic [DEF_DATA_W-1:0] a;
        logic [DEF_DATA_W-1:0] b;
        logic [DEF_DATA_W-1:0] imm;
        logic [DEF_SEL_W-1:0]  rd;
        logic                  reg_write;
        logic [DEF_DATA_W-1:0] pc2;
        logic                  halt;
    } id_ex_t;

endpackage

// File: rtl/regfile_bypass.sv
// Two-read, one-write register file; a read of the register being written
// this cycle returns the incoming writeback data.
module regfile_bypass #(
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = 16,
    parameter int SEL_W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [SEL_W-1:0]  wsel,
    input  logic [DATA_W-1:0] wdata,
    input  logic [SEL_W-1:0]  rsel_a,
    input  logic [SEL_W-1:0]  rsel_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (we) begin
            regs[wsel] <= wdata;
        end
    end

    assign rdata_a = (we && wsel == rsel_a) ? wdata : regs[rsel_a];
    assign rdata_b = (we && wsel == rsel_b) ? wdata : regs[rsel_b];

endmodule

// File: rtl/decode_stage_sb.sv
// Decode stage: register read with bypass, pending-write scoreboard for RAW
// stalls, immediate extension and the ID/EX pipeline register.
module decode_stage_sb
    import pipe_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int INSTR_W  = DEF_INSTR_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int SEL_W    = DEF_SEL_W,
    parameter int PEND_W   = DEF_PEND_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_valid,
    input  logic [INSTR_W-1:0] if_instr,
    input  logic [DATA_W-1:0]  if_pc2,
    output logic               id_ready,
    input  logic [SEL_W-1:0]   dec_rd,
    input  logic               dec_reg_write,
    input  logic               dec_uses_rs,
    input  logic               dec_uses_rt,
    input  logic [2:0]         dec_imm_sel,
    input  logic               dec_halt,
    input  logic               ex_hold,
    input  logic               flush,
    input  logic               wb_en,
    input  logic [SEL_W-1:0]   wb_reg,
    input  logic [DATA_W-1:0]  wb_data,
    output logic               ex_valid,
    output logic [DATA_W-1:0]  ex_a,
    output logic [DATA_W-1:0]  ex_b,
    output logic [DATA_W-1:0]  ex_imm,
    output logic [SEL_W-1:0]   ex_rd,
    output logic               ex_reg_write,
    output logic [DATA_W-1:0]  ex_pc2,
    output logic               ex_halt,
    output logic               halted,
    output logic               err
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic [SEL_W-1:0]    rs_sel, rt_sel;
    logic [DATA_W-1:0]   rdata_a, rdata_b;
    logic [DATA_W-1:0]   imm_ext;
    logic                imm_illegal;
    logic                rs_busy, rt_busy, rd_full, hazard, issue;
    logic [PEND_W-1:0]   pend [NUM_REGS];
    logic [NUM_REGS-1:0] pend_inc, pend_dec;
    id_ex_t              id_ex_d, id_ex_q;
    logic                unused_instr;

    assign rs_sel       = if_instr[8 +: SEL_W];
    assign rt_sel       = if_instr[5 +: SEL_W];
    assign unused_instr = ^if_instr[INSTR_W-1:11];

    regfile_bypass #(
        .NUM_REGS(NUM_REGS),
        .DATA_W  (DATA_W),
        .SEL_W   (SEL_W)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (wb_en),
        .wsel   (wb_reg),
        .wdata  (wb_data),
        .rsel_a (rs_sel),
        .rsel_b (rt_sel),
        .rdata_a(rdata_a),
        .rdata_b(rdata_b)
    );

    // A source whose only outstanding write is retiring right now is not a hazard: the bypass covers it.
    assign rs_busy  = dec_uses_rs && (pend[rs_sel] != '0)
                      && !(pend[rs_sel] == PEND_ONE && wb_en && wb_reg == rs_sel);
    assign rt_busy  = dec_uses_rt && (pend[rt_sel] != '0)
                      && !(pend[rt_sel] == PEND_ONE && wb_en && wb_reg == rt_sel);
    assign rd_full  = dec_reg_write && (pend[dec_rd] == PEND_MAX);
    assign hazard   = rs_busy || rt_busy || rd_full;
    assign id_ready = !hazard && !ex_hold && !halted;
    assign issue    = if_valid && id_ready && !flush;

    always_comb begin
        imm_ext     = '0;
        imm_illegal = 1'b0;
        case (dec_imm_sel)
            IMM_S5:  imm_ext = {{(DATA_W-5){if_instr[4]}}, if_instr[4:0]};
            IMM_Z5:  imm_ext = {{(DATA_W-5){1'b0}}, if_instr[4:0]};
            IMM_S8:  imm_ext = {{(DATA_W-8){if_instr[7]}}, if_instr[7:0]};
            IMM_Z8:  imm_ext = {{(DATA_W-8){1'b0}}, if_instr[7:0]};
            IMM_S11: imm_ext = {{(DATA_W-11){if_instr[10]}}, if_instr[10:0]};
            default: imm_illegal = 1'b1;
        endcase
    end

    always_comb begin
        pend_inc = '0;
        pend_dec = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            pend_inc[r] = issue && dec_reg_write && (dec_rd == SEL_W'(r));
            pend_dec[r] = wb_en && (wb_reg == SEL_W'(r));
        end
    end

    // An issue and a retirement on the same register cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) pend[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (pend_inc[r] && !pend_dec[r])
                    pend[r] <= pend[r] + PEND_ONE;
                else if (pend_dec[r] && !pend_inc[r] && pend[r] != '0)
                    pend[r] <= pend[r] - PEND_ONE;
            end
        end
    end

    always_comb begin
        id_ex_d = '0;
        if (issue) begin
            id_ex_d.valid     = 1'b1;
            id_ex_d.a         = rdata_a;
            id_ex_d.b         = rdata_b;
            id_ex_d.imm       = imm_ext;
            id_ex_d.rd        = dec_rd;
            id_ex_d.reg_write = dec_reg_write;
            id_ex_d.pc2       = if_pc2;
            id_ex_d.halt      = dec_halt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex_q <= '0;
            halted  <= 1'b0;
            err     <= 1'b0;
        end else begin
            if (!ex_hold) id_ex_q <= id_ex_d;
            halted <= halted || (issue && dec_halt);
            err    <= issue && imm_illegal;
        end
    end

    assign ex_valid     = id_ex_q.valid;
    assign ex_a         = id_ex_q.a;
    assign ex_b         = id_ex_q.b;
    assign ex_imm       = id_ex_q.imm;
    assign ex_rd        = id_ex_q.rd;
    assign ex_reg_write = id_ex_q.reg_write;
    assign ex_pc2       = id_ex_q.pc2;
    assign ex_halt      = id_ex_q.halt;

endmodule

// File: doc/decode_stage_sb.md
Name: decode_stage_sb

Overview:
- Parametrised decode stage for the 5-stage pipeline, sitting between the IF/ID register and EX.
- Contains a write-through-bypass register file, a per-register pending-write scoreboard and the ID/EX pipeline register.
- Stalls on RAW hazards and inserts bubbles. It supports downstream hold and branch flush.
- Immediate extension is selected by the control unit's imm_sel code. No forwarding network is assumed.

Parameters:
- DATA_W, 16, datapath and register width
- INSTR_W, 16, instruction width; register fields are at [10:8] (rs) and [7:5] (rt), immediates at [4:0], [7:0] and [10:0]
- NUM_REGS, 8, number of architectural registers
- SEL_W, 3, register select width, equal to $clog2(NUM_REGS)
- PEND_W, 2, width of each scoreboard counter (maximum number of in-flight writes per register)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_valid  in  1  IF/ID holds a valid instruction
- if_instr  in  INSTR_W  instruction
- if_pc2  in  DATA_W  PC+2 of the instruction
- id_ready  out  1  decode consumes the instruction this cycle
- dec_rd  in  SEL_W  destination register from the control unit
- dec_reg_write  in  1  instruction writes a register
- dec_uses_rs  in  1  instruction reads rs
- dec_uses_rt  in  1  instruction reads rt
- dec_imm_sel  in  3  immediate select code
- dec_halt  in  1  instruction is HALT
- ex_hold  in  1  EX cannot accept; ID/EX register holds its contents
- flush  in  1  squash the instruction currently in ID (branch/jump taken in EX)
- wb_en  in  1  writeback enable
- wb_reg  in  SEL_W  writeback register
- wb_data  in  DATA_W  writeback data
- ex_valid  out  1  ID/EX holds a valid instruction
- ex_a  out  DATA_W  rs value
- ex_b  out  DATA_W  rt value
- ex_imm  out  DATA_W  extended immediate
- ex_rd  out  SEL_W  destination register
- ex_reg_write  out  1  destination write flag
- ex_pc2  out  DATA_W  PC+2
- ex_halt  out  1  HALT marker
- halted  out  1  sticky; set once HALT has been issued
- err  out  1  registered pulse on illegal imm_sel for a valid instruction

Behaviour:
- Reset (synchronous, active-high):
  - all registers and all scoreboard counters clear to 0
  - every ex_* output, halted and err go to 0
- Register file:
  - A write is applied at the clock edge when wb_en is high.
  - A read whose select equals wb_reg while wb_en is high returns wb_data (same-cycle bypass).
  - R0 is an ordinary register.
- Scoreboard, pend[r]:
  - +1 on issue when dec_reg_write is high and dec_rd==r.
  - -1 when wb_en is high and wb_reg==r.
  - Both events in the same cycle leave the counter unchanged.
  - Decrementing at 0 is ignored (no underflow).
- Hazard; the instruction stalls if any of the following hold:
  - dec_uses_rs and pend[rs]!=0, unless (pend[rs]==1 and wb_en and wb_reg==rs)
  - the same condition for rt
  - dec_reg_write and pend[rd] is at its maximum value
- id_ready = !hazard & !ex_hold & !halted.
- issue = if_valid & id_ready & !flush.
- ID/EX register, at each clock edge:
  - ex_hold high: hold all contents. The scoreboard only decrements.
  - else if issue: load the instruction and set ex_valid=1.
  - else: load a bubble (ex_valid=0, ex_reg_write=0, ex_halt=0); data fields are don't-care but set to 0.
- Flush:
  - Flush has priority over issue. The ID instruction is dropped and the scoreboard is not incremented.
  - id_ready still reflects the stall conditions, so IF advances during a flush.
- Immediates, selected by dec_imm_sel:
  - 0: sign-extend [4:0]
  - 1: zero-extend [4:0]
  - 2: sign-extend [7:0]
  - 3: zero-extend [7:0]
  - 4: sign-extend [10:0]
  - 5–7: illegal; ex_imm=0 and err pulses for one cycle on issue
- Latency: one cycle from issue to ex_*.
- HALT: on issue with dec_halt high, ex_halt=1 and halted is set. Nothing further issues until reset. halted is set even if ex_hold rises in the next cycle.
- Reset asserted mid-stall clears everything; no partial state persists.

Decomposition:
- Shared package pipe_pkg holds:
  - the imm_sel encodings (IMM_S5, IMM_Z5, IMM_S8, IMM_Z8, IMM_S11)
  - the default parameter constants
  - an id_ex_t struct bundling the ex_* fields
- One sub-module, regfile_bypass: NUM_REGS × DATA_W, two read ports, one write port, bypass.
- Scoreboard, immediate mux and ID/EX register stay inline.

Test Plan:
- Reset, then issue ADD with rs=1, rt=2, rd=3 and R1=5, R2=7 preloaded via WB -> next cycle ex_valid=1, ex_a=5, ex_b=7, ex_rd=3, pend[3]=1.
- Issue a write to R3, then immediately a reader of R3 -> id_ready=0 until wb_en with wb_reg=3. In that WB cycle the reader issues with ex_a=wb_data (bypass) and pend[3] returns to 0.
- Issue with ex_hold=1 for 3 cycles -> ex_* outputs are stable and id_ready=0. Release -> the held instruction advances.
- Flush asserted with if_valid=1 and dec_reg_write=1, rd=4 -> next-cycle ex_valid=0 and pend[4] stays 0.
- Immediate checks:
  - instr[4:0]=5'b10000 with sel 0 -> 0xFFF0
  - same field with sel 1 -> 0x0010
  - instr[10:0]=0x400 with sel 4 -> 0xFC00
  - sel 6 -> ex_imm=0 and err pulses for one cycle
- HALT issued -> ex_halt=1 and halted=1. Subsequent valid instructions produce no issue and id_ready=0. Reset clears halted.
